// File: rtl/power_probe_pkg.sv
// Shared definitions for the power-rewrite toggle probe.
//   probe_state_e : FILL/SNAP window FSM encoding
//   popcount      : counts set bits among the low 'lanes' bits of a 64-bit vector
//   sat_add       : adds a popcount to a w-bit accumulator, clamping at 2^w-1
package power_probe_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    SNAP = 1'b1
  } probe_state_e;

  localparam int unsigned MAX_LANES = 64;

  function automatic logic [6:0] popcount(input logic [MAX_LANES-1:0] v,
                                          input int unsigned          lanes);
    logic [6:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (i < lanes && v[i]) n = n + 7'd1;
    end
    return n;
  endfunction

  // Sum is formed one bit wider than the accumulator so a carry past the
  // limit is seen instead of wrapping.
  function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                          input logic [6:0]  inc,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, acc} + {58'd0, inc};
    lim = {1'b0, {64{1'b1}}} >> (64 - w);
    return (sum > lim) ? lim[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/sub_toggle_lane.sv
// One combinational bit-slice of the 4-input power-rewrite sub-circuit.
//   i_a..i_d : slice inputs
//   o_t      : internal node t = ~a & d
//   o_q      : internal node q = ~b & (a | c)
//   o_y      : output node   y = c ^ t ^ q
module sub_toggle_lane (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_d,
  output logic o_y,
  output logic o_t,
  output logic o_q
);

  always_comb begin
    o_t = ~i_a & i_d;
    o_q = ~i_b & (i_a | i_c);
    o_y = i_c ^ o_t ^ o_q;
  end

endmodule

// File: rtl/sub_toggle_probe.sv
// Registered multi-lane evaluator with windowed switching-activity report.
//   clk, rst (sync, active-high)
//   in_valid, in_a..in_d      : sample strobe and per-lane inputs
//   out_valid, out_y          : registered strobe and per-lane result
//   rpt_valid / rpt_ready     : report handshake
//   rpt_tog_y/_t/_q           : per-node toggle counts of the last window
//   rpt_overrun               : sticky, window ended while a report was held
module sub_toggle_probe
  import power_probe_pkg::*;
#(
  parameter int unsigned LANES  = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned WINDOW = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [LANES-1:0] in_a,
  input  logic [LANES-1:0] in_b,
  input  logic [LANES-1:0] in_c,
  input  logic [LANES-1:0] in_d,
  output logic             out_valid,
  output logic [LANES-1:0] out_y,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_tog_y,
  output logic [CNT_W-1:0] rpt_tog_t,
  output logic [CNT_W-1:0] rpt_tog_q,
  output logic             rpt_overrun
);

  localparam int unsigned SMP_W = $clog2(WINDOW);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(WINDOW - 1);

  logic [LANES-1:0] w_y, w_t, w_q;
  logic [LANES-1:0] r_t, r_q;
  logic [63:0]      w_xy, w_xt, w_xq;
  logic [6:0]       w_dy, w_dt, w_dq;
  logic             w_pending;

  probe_state_e     r_state;
  logic [SMP_W-1:0] r_smp;
  logic             r_base;
  logic [CNT_W-1:0] r_acc_y, r_acc_t, r_acc_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sub_toggle_lane u_lane (
      .i_a (in_a[g]),
      .i_b (in_b[g]),
      .i_c (in_c[g]),
      .i_d (in_d[g]),
      .o_y (w_y[g]),
      .o_t (w_t[g]),
      .o_q (w_q[g])
    );
  end

  always_comb begin
    w_xy = '0;
    w_xt = '0;
    w_xq = '0;
    w_xy[LANES-1:0] = w_y ^ out_y;
    w_xt[LANES-1:0] = w_t ^ r_t;
    w_xq[LANES-1:0] = w_q ^ r_q;
    w_dy = r_base ? 7'd0 : popcount(w_xy, LANES);
    w_dt = r_base ? 7'd0 : popcount(w_xt, LANES);
    w_dq = r_base ? 7'd0 : popcount(w_xq, LANES);
    // A report being accepted in the snapshot cycle frees the slot.
    w_pending = rpt_valid & ~rpt_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_y       <= '0;
      r_t         <= '0;
      r_q         <= '0;
      r_state     <= FILL;
      r_smp       <= '0;
      r_base      <= 1'b1;
      r_acc_y     <= '0;
      r_acc_t     <= '0;
      r_acc_q     <= '0;
      rpt_valid   <= 1'b0;
      rpt_tog_y   <= '0;
      rpt_tog_t   <= '0;
      rpt_tog_q   <= '0;
      rpt_overrun <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_y <= w_y;
        r_t   <= w_t;
        r_q   <= w_q;
      end

      case (r_state)
        FILL: begin
          if (in_valid) begin
            r_acc_y <= CNT_W'(sat_add(64'(r_acc_y), w_dy, CNT_W));
            r_acc_t <= CNT_W'(sat_add(64'(r_acc_t), w_dt, CNT_W));
            r_acc_q <= CNT_W'(sat_add(64'(r_acc_q), w_dq, CNT_W));
            r_base  <= 1'b0;
            if (r_smp == SMP_LAST) begin
              r_state <= SNAP;
              r_smp   <= '0;
            end else begin
              r_smp <= r_smp + SMP_W'(1);
            end
          end
        end
        SNAP: begin
          // A sample landing here is the new window's baseline: it loads the
          // previous-value registers above but adds nothing.
          r_acc_y <= '0;
          r_acc_t <= '0;
          r_acc_q <= '0;
          r_base  <= ~in_valid;
          r_smp   <= in_valid ? SMP_W'(1) : '0;
          r_state <= FILL;
        end
        default: r_state <= FILL;
      endcase

      if (r_state == SNAP && !w_pending) begin
        rpt_valid <= 1'b1;
        rpt_tog_y <= r_acc_y;
        rpt_tog_t <= r_acc_t;
        rpt_tog_q <= r_acc_q;
      end else if (rpt_valid && rpt_ready) begin
        rpt_valid <= 1'b0;
      end

      if (r_state == SNAP && w_pending) rpt_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sub_toggle_probe.sv
// Directed bench for sub_toggle_probe: truth table, windowed toggle counts,
// handshake/overrun, gapped input, reset behaviour and saturation.
module tb_sub_toggle_probe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, rpt_ready;
  logic [7:0] in_a, in_b, in_c, in_d;

  logic        out_valid, rpt_valid, rpt_overrun;
  logic [7:0]  out_y;
  logic [15:0] tog_y, tog_t, tog_q;

  logic        s_out_valid, s_rpt_valid, s_rpt_overrun;
  logic [7:0]  s_out_y;
  logic [3:0]  s_tog_y, s_tog_t, s_tog_q;

  sub_toggle_probe #(.LANES(8), .CNT_W(16), .WINDOW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid), .out_y(out_y),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
    .rpt_tog_y(tog_y), .rpt_tog_t(tog_t), .rpt_tog_q(tog_q),
    .rpt_overrun(rpt_overrun)
  );

  sub_toggle_probe #(.LANES(8), .CNT_W(4), .WINDOW(8)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(s_out_valid), .out_y(s_out_y),
    .rpt_valid(s_rpt_valid), .rpt_ready(rpt_ready),
    .rpt_tog_y(s_tog_y), .rpt_tog_t(s_tog_t), .rpt_tog_q(s_tog_q),
    .rpt_overrun(s_rpt_overrun)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d);
    in_a = a; in_b = b; in_c = c; in_d = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_ready();
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
  endtask

  // y for index {a,b,c,d}, bit i = y of combination i
  logic [15:0] truth = 16'hC36A;
  logic [3:0]  v;
  logic [7:0]  alt [4];
  logic [7:0]  ramp [4];
  logic [7:0]  rs [4];

  initial begin
    alt  = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    ramp = '{8'h01, 8'h03, 8'h07, 8'h0F};
    rs   = '{8'h0F, 8'hFF, 8'hFF, 8'h00};
    rst = 1'b0; in_valid = 1'b0; rpt_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0;

    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_y", 64'(out_y), 64'd0);
    chk("rst_rpt_valid", 64'(rpt_valid), 64'd0);
    chk("rst_tog_y", 64'(tog_y), 64'd0);
    chk("rst_tog_q", 64'(tog_q), 64'd0);
    chk("rst_overrun", 64'(rpt_overrun), 64'd0);

    // Truth sweep, broadcast to all lanes
    rpt_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      send({8{v[3]}}, {8{v[2]}}, {8{v[1]}}, {8{v[0]}});
      chk("truth_y", 64'(out_y), truth[i] ? 64'hFF : 64'h00);
    end
    chk("truth_out_valid", 64'(out_valid), 64'd1);
    tick();
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_out_y_hold", 64'(out_y), 64'hFF);

    // Window A: a=b=d=0 -> t=0, q=c, y=0
    do_reset();
    rpt_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h00, 8'h00, alt[i], 8'h00);
    chk("A_rpt_early", 64'(rpt_valid), 64'd0);
    tick();
    chk("A_rpt_valid", 64'(rpt_valid), 64'd1);
    chk("A_tog_y", 64'(tog_y), 64'd0);
    chk("A_tog_t", 64'(tog_t), 64'd0);
    chk("A_tog_q", 64'(tog_q), 64'd24);
    tick();
    chk("A_hold_valid", 64'(rpt_valid), 64'd1);
    chk("A_hold_q", 64'(tog_q), 64'd24);
    pulse_ready();
    chk("A_drop", 64'(rpt_valid), 64'd0);

    // Window B: b=1 -> q=0, y=c
    for (int i = 0; i < 4; i++) send(8'h00, 8'hFF, ~alt[i], 8'h00);
    tick();
    chk("B_rpt_valid", 64'(rpt_valid), 64'd1);
    chk("B_tog_y", 64'(tog_y), 64'd24);
    chk("B_tog_t", 64'(tog_t), 64'd0);
    chk("B_tog_q", 64'(tog_q), 64'd0);
    pulse_ready();

    // Window C: a=0,b=1,c=0 -> t=d, y=d, one new lane set per sample
    for (int i = 0; i < 4; i++) send(8'h00, 8'hFF, 8'h00, ramp[i]);
    tick();
    chk("C_tog_y", 64'(tog_y), 64'd3);
    chk("C_tog_t", 64'(tog_t), 64'd3);
    chk("C_overrun", 64'(rpt_overrun), 64'd0);

    // Window D completes while C is still held
    for (int i = 0; i < 4; i++) send(8'h00, 8'hFF, alt[i], 8'h00);
    tick();
    chk("D_held_valid", 64'(rpt_valid), 64'd1);
    chk("D_held_t", 64'(tog_t), 64'd3);
    chk("D_held_y", 64'(tog_y), 64'd3);
    chk("D_overrun", 64'(rpt_overrun), 64'd1);
    pulse_ready();
    chk("D_drop", 64'(rpt_valid), 64'd0);
    chk("D_overrun_sticky", 64'(rpt_overrun), 64'd1);

    // 50% duty input
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(8'h00, 8'hFF, alt[i], 8'h00);
      tick();
    end
    chk("G_rpt_early", 64'(rpt_valid), 64'd0);
    send(8'h00, 8'hFF, alt[3], 8'h00);
    tick();
    chk("G_rpt_valid", 64'(rpt_valid), 64'd1);
    chk("G_tog_y", 64'(tog_y), 64'd24);
    chk("G_tog_q", 64'(tog_q), 64'd0);

    // Reset drops a pending report
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("R_rpt_dropped", 64'(rpt_valid), 64'd0);
    chk("R_tog_y_clr", 64'(tog_y), 64'd0);

    // Reset after 3 of 4 samples discards the partial window
    for (int i = 0; i < 3; i++) send(8'h00, 8'hFF, ~alt[i], 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h00, 8'hFF, rs[i], 8'h00);
    chk("M_rpt_early", 64'(rpt_valid), 64'd0);
    tick();
    chk("M_rpt_valid", 64'(rpt_valid), 64'd1);
    chk("M_tog_y", 64'(tog_y), 64'd12);

    // Saturation on the CNT_W=4, WINDOW=8 instance: 7*8 = 56 clamps to 15
    do_reset();
    for (int i = 0; i < 8; i++) send(8'h00, 8'hFF, alt[i % 4], 8'h00);
    chk("S_rpt_early", 64'(s_rpt_valid), 64'd0);
    tick();
    chk("S_rpt_valid", 64'(s_rpt_valid), 64'd1);
    chk("S_tog_y", 64'(s_tog_y), 64'd15);
    chk("S_tog_t", 64'(s_tog_t), 64'd0);
    chk("S_tog_q", 64'(s_tog_q), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
